// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 line watchdog.
package ps2_pkg;

   // Default thresholds in 50 MHz clock cycles
   localparam int unsigned T150US_50M  = 7500;
   localparam int unsigned T1200US_50M = 60000;

   // Edge selections for EDGE_MODE
   localparam int unsigned EDGE_FALL = 0;
   localparam int unsigned EDGE_RISE = 1;
   localparam int unsigned EDGE_BOTH = 2;

   // True when the transition prev -> cur matches the selected edge
   function automatic logic edge_match(input int unsigned mode,
                                       input logic        prev,
                                       input logic        cur);
      logic fall;
      logic rise;
      fall = prev & ~cur;
      rise = ~prev & cur;
      case (mode)
         EDGE_FALL: return fall;
         EDGE_RISE: return rise;
         default:   return fall | rise;
      endcase
   endfunction

endpackage

// File: rtl/ps2_edge_detect.sv
// Synchronises the raw PS/2 clock line and emits a registered one-cycle
// pulse for each edge of the selected polarity. The line is tracked even
// while disabled so re-enabling never fires on a stale transition.
module ps2_edge_detect
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_MODE   = EDGE_FALL
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic enable,
   output logic edge_pulse
);

   // Parameter sanity
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("ps2_edge_detect: SYNC_STAGES must be at least 2");
   end
   if (EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
      $error("ps2_edge_detect: EDGE_MODE must be 0, 1 or 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   line_c;

   assign line_c = sync_q[SYNC_STAGES-1];

   // Synchroniser chain, idle-high on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_clk};
      end
   end

   // Previous synchronised value and registered edge pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q     <= 1'b1;
         edge_pulse <= 1'b0;
      end else begin
         prev_q     <= line_c;
         edge_pulse <= enable & edge_match(EDGE_MODE, prev_q, line_c);
      end
   end

endmodule

// File: rtl/ps2_watchdog_timer.sv
// PS/2 clock-line inactivity watchdog: saturating counter cleared by the
// selected line edge or a software restart, with short (bit-gap) and long
// (bus-idle / host-request) threshold flags.
// Optional sticky timeout flag enabled by defining PS2_WDT_STICKY_EN.
module ps2_watchdog_timer
   import ps2_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned T_SHORT     = T150US_50M,
   parameter int unsigned T_LONG      = T1200US_50M,
   parameter int unsigned EDGE_MODE   = EDGE_FALL,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             enable,
   input  logic             restart,
`ifdef PS2_WDT_STICKY_EN
   input  logic             timeout_clr,
   output logic             timeout_sticky,
`endif
   output logic             edge_pulse,
   output logic             timer_short_done,
   output logic             timer_long_done,
   output logic             bus_idle,
   output logic [CNT_W-1:0] count
);

   // Parameter sanity
   if (T_SHORT >= T_LONG) begin : g_bad_thresh
      $error("ps2_watchdog_timer: T_SHORT must be below T_LONG");
   end
   if (64'(T_LONG) >= (64'd1 << CNT_W)) begin : g_bad_width
      $error("ps2_watchdog_timer: T_LONG does not fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(T_SHORT);
   localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(T_LONG);

   logic [CNT_W-1:0] count_c;

   // Line synchroniser and edge filter
   ps2_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
   ) u_edge (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .enable     (enable),
      .edge_pulse (edge_pulse)
   );

   // Next count: disable, then clear, then increment, else saturate
   always_comb begin
      count_c = count;
      if (!enable) begin
         count_c = '0;
      end else if (restart || edge_pulse) begin
         count_c = '0;
      end else if (count < LONG_V) begin
         count_c = count + CNT_W'(1);
      end else begin
         count_c = LONG_V;
      end
   end

   // Counter and threshold flags, registered from the next count so each
   // flag lines up with the cycle the count shows the threshold value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count            <= '0;
         timer_short_done <= 1'b0;
         timer_long_done  <= 1'b0;
         bus_idle         <= 1'b0;
      end else begin
         count            <= count_c;
         timer_short_done <= (count_c == SHORT_V);
         timer_long_done  <= (count_c == LONG_V) && (count != LONG_V);
         bus_idle         <= (count_c == LONG_V);
      end
   end

`ifdef PS2_WDT_STICKY_EN
   // Sticky timeout: a long-timeout pulse beats a coincident clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_sticky <= 1'b0;
      end else if (timer_long_done) begin
         timeout_sticky <= 1'b1;
      end else if (timeout_clr) begin
         timeout_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_ps2_watchdog_timer.sv
// Self-checking bench for ps2_watchdog_timer: a falling-edge and a
// rising-edge instance share stimulus and are compared every cycle against
// a model phrased as "cycles since the last clear, capped at T_LONG".
module tb_ps2_watchdog_timer;

   localparam int unsigned CW = 12;
   localparam int unsigned TS = 150;
   localparam int unsigned TL = 1200;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ps2_clk;
   logic          enable;
   logic          restart;
`ifdef PS2_WDT_STICKY_EN
   logic          timeout_clr;
   logic [1:0]    st;
`endif
   logic [1:0]    ep, sd, ld, bi;
   logic [CW-1:0] cnt_f, cnt_r;

   int passes = 0;
   int checks = 0;

   // Reference model state
   bit [2:0] hist;            // [0] newest line sample, [2] oldest
   bit       m_ep [2];
   int       m_cnt [2];
   bit       m_ld [2];
   bit       m_st [2];
   longint   last_clear [2];
   longint   cyc = 0;

   always #5 clk = ~clk;

   ps2_watchdog_timer #(
      .CNT_W(CW), .T_SHORT(TS), .T_LONG(TL), .EDGE_MODE(0), .SYNC_STAGES(2)
   ) dut_f (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .enable(enable),
      .restart(restart),
`ifdef PS2_WDT_STICKY_EN
      .timeout_clr(timeout_clr), .timeout_sticky(st[0]),
`endif
      .edge_pulse(ep[0]), .timer_short_done(sd[0]),
      .timer_long_done(ld[0]), .bus_idle(bi[0]), .count(cnt_f)
   );

   ps2_watchdog_timer #(
      .CNT_W(CW), .T_SHORT(TS), .T_LONG(TL), .EDGE_MODE(1), .SYNC_STAGES(2)
   ) dut_r (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .enable(enable),
      .restart(restart),
`ifdef PS2_WDT_STICKY_EN
      .timeout_clr(timeout_clr), .timeout_sticky(st[1]),
`endif
      .edge_pulse(ep[1]), .timer_short_done(sd[1]),
      .timer_long_done(ld[1]), .bus_idle(bi[1]), .count(cnt_r)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic model_reset();
      hist = 3'b111;
      for (int i = 0; i < 2; i++) begin
         m_ep[i] = 1'b0;
         m_cnt[i] = 0;
         m_ld[i] = 1'b0;
         m_st[i] = 1'b0;
         last_clear[i] = cyc;
      end
   endtask

   // One clock: advance the model with the inputs the DUT just sampled,
   // then compare every output of both instances
   task automatic tick();
      bit     fall, rise, sel, ld_old;
      int     prev;
      longint age;
      @(posedge clk);
      if (reset) begin
         cyc++;
         fall = hist[2] && !hist[1];
         rise = !hist[2] && hist[1];
         for (int i = 0; i < 2; i++) begin
            sel = (i == 0) ? fall : rise;
            if (!enable || restart || m_ep[i]) last_clear[i] = cyc;
            ld_old = m_ld[i];
            prev = m_cnt[i];
            age = cyc - last_clear[i];
            m_cnt[i] = (age > longint'(TL)) ? int'(TL) : int'(age);
            m_ld[i] = (m_cnt[i] == int'(TL)) && (prev != int'(TL));
            m_ep[i] = enable && sel;
`ifdef PS2_WDT_STICKY_EN
            if (ld_old) m_st[i] = 1'b1;
            else if (timeout_clr) m_st[i] = 1'b0;
`else
            if (ld_old) m_st[i] = 1'b1;
`endif
         end
         hist = {hist[1:0], ps2_clk};
      end
      #1;
      chk("count_f", 32'(cnt_f), 32'(m_cnt[0]));
      chk("count_r", 32'(cnt_r), 32'(m_cnt[1]));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("edge_pulse%0d", i), 32'(ep[i]), 32'(m_ep[i]));
         chk($sformatf("short_done%0d", i), 32'(sd[i]), 32'(m_cnt[i] == int'(TS)));
         chk($sformatf("long_done%0d", i), 32'(ld[i]), 32'(m_ld[i]));
         chk($sformatf("bus_idle%0d", i), 32'(bi[i]), 32'(m_cnt[i] == int'(TL)));
`ifdef PS2_WDT_STICKY_EN
         chk($sformatf("sticky%0d", i), 32'(st[i]), 32'(m_st[i]));
`endif
      end
   endtask

   // Tick until the falling-edge model count hits target, bounded
   task automatic wait_cnt(input int target, input int budget, input string tag);
      int n = 0;
      while (m_cnt[0] != target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(cnt_f), 32'(target));
   endtask

   initial begin
      int ld_seen;
      int max_cnt;
      reset = 1'b0;
      ps2_clk = 1'b1;
      enable = 1'b1;
      restart = 1'b0;
`ifdef PS2_WDT_STICKY_EN
      timeout_clr = 1'b0;
`endif
      model_reset();

      // Reset state
      repeat (3) tick();
      chk("reset_count", 32'(cnt_f), 32'd0);
      reset = 1'b1;

      // Idle line: short at TS, one long at TL, then hold saturated
      ld_seen = 0;
      repeat (TL + 400) begin
         tick();
         ld_seen += int'(ld[0]);
      end
      chk("long_once", 32'(ld_seen), 32'd1);
      chk("saturated", 32'(cnt_f), 32'(TL));

      // Edge while saturated drops bus_idle
      ps2_clk = 1'b0;
      repeat (4) tick();
      chk("sat_clear", 32'(cnt_f), 32'd0);

      // Periodic falling edges well inside the short threshold
      max_cnt = 0;
      for (int p = 0; p < 20; p++) begin
         ps2_clk = 1'b1;
         repeat (50) begin tick(); if (int'(cnt_f) > max_cnt) max_cnt = int'(cnt_f); end
         ps2_clk = 1'b0;
         repeat (50) begin tick(); if (int'(cnt_f) > max_cnt) max_cnt = int'(cnt_f); end
      end
      chk("periodic_max", 32'(max_cnt <= 103), 32'd1);
      ps2_clk = 1'b1;

      // Restart in the cycle the count would reach TS
      restart = 1'b1; tick(); restart = 1'b0;
      wait_cnt(int'(TS) - 1, 2 * int'(TL), "reach_short_m1");
      restart = 1'b1; tick(); restart = 1'b0;
      chk("restart_count", 32'(cnt_f), 32'd0);
      chk("restart_no_short", 32'(sd[0]), 32'd0);

      // Asynchronous reset mid-count
      wait_cnt(600, 2 * int'(TL), "reach_600");
      #2 reset = 1'b0;
      #1;
      chk("async_count", 32'(cnt_f), 32'd0);
      chk("async_count_r", 32'(cnt_r), 32'd0);
      chk("async_ep", 32'(ep), 32'd0);
      chk("async_sd", 32'(sd), 32'd0);
      chk("async_ld", 32'(ld), 32'd0);
      chk("async_bi", 32'(bi), 32'd0);
      model_reset();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("restart_from_1", 32'(cnt_f), 32'd1);

      // Randomised traffic: quiet stretches, edge bursts, kicks, enable drops
      for (int b = 0; b < 40; b++) begin
         int len;
         len = int'($urandom_range(1, 1400));
         for (int j = 0; j < len; j++) begin
            restart = ($urandom_range(0, 299) == 0);
`ifdef PS2_WDT_STICKY_EN
            timeout_clr = ($urandom_range(0, 63) == 0);
`endif
            tick();
         end
         restart = 1'b0;
         for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
            ps2_clk = ~ps2_clk;
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 12)) tick();
         end
         enable = 1'b1;
      end
`ifdef PS2_WDT_STICKY_EN
      timeout_clr = 1'b0;
`endif

`ifdef PS2_WDT_STICKY_EN
      // Sticky: set wins over a coincident clear, isolated clear drops it
      ps2_clk = 1'b1;
      repeat (4) tick();
      restart = 1'b1; tick(); restart = 1'b0;
      wait_cnt(int'(TL), 2 * int'(TL), "sticky_first_long");
      repeat (2) tick();
      chk("sticky_set", 32'(st[0]), 32'd1);
      restart = 1'b1; tick(); restart = 1'b0;
      wait_cnt(int'(TL), 2 * int'(TL), "sticky_second_long");
      chk("second_long_pulse", 32'(ld[0]), 32'd1);
      timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
      chk("sticky_set_wins", 32'(st[0]), 32'd1);
      repeat (3) tick();
      timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
      chk("sticky_cleared", 32'(st[0]), 32'd0);
`endif

      repeat (5) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
